// File: rtl/fsm_result_unload.sv
// rtl/fsm_result_unload.sv - unloads the N x N result matrix from RAM to the UART, four bytes per word MSB first
module fsm_result_unload #(
   parameter int N      = 4,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_c_rd_addr,
   input  logic [DATA_W-1:0] ram_c_rd_data,
   output logic [7:0]        uart_tx_data,
   output logic              uart_send_data,
   input  logic              uart_tx_done,
   output logic              busy,
   output logic              done,
   output logic [3:0]        state_val
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] RD_WAIT = 4'd1;
   localparam logic [3:0] LATCH   = 4'd2;
   localparam logic [3:0] SEND    = 4'd3;
   localparam logic [3:0] WAIT_TX = 4'd4;
   localparam logic [3:0] FINISH  = 4'd5;

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [3:0]        state;
   logic [CW-1:0]     row;
   logic [CW-1:0]     col;
   logic [1:0]        byte_idx;
   logic [1:0]        rd_cnt;
   logic [DATA_W-1:0] word;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return ADDR_W'(int'(r) * N + int'(c));
   endfunction

   function automatic logic [7:0] sel_byte(input logic [DATA_W-1:0] w, input logic [1:0] b);
      case (b)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   assign state_val = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         row            <= '0;
         col            <= '0;
         byte_idx       <= '0;
         rd_cnt         <= '0;
         word           <= '0;
         ram_c_rd_addr  <= '0;
         uart_tx_data   <= '0;
         uart_send_data <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         uart_send_data <= 1'b0;
         done           <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  row           <= '0;
                  col           <= '0;
                  ram_c_rd_addr <= '0;
                  rd_cnt        <= 2'(RD_LAT - 1);
                  busy          <= 1'b1;
                  state         <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (rd_cnt == 2'd0) state <= LATCH;
               else                rd_cnt <= rd_cnt - 2'd1;
            end
            LATCH: begin
               word           <= ram_c_rd_data;
               byte_idx       <= 2'd0;
               uart_tx_data   <= sel_byte(ram_c_rd_data, 2'd0);
               uart_send_data <= 1'b1;
               state          <= SEND;
            end
            SEND: state <= WAIT_TX;
            WAIT_TX: begin
               if (uart_tx_done) begin
                  if (byte_idx != 2'd3) begin
                     byte_idx       <= byte_idx + 2'd1;
                     uart_tx_data   <= sel_byte(word, byte_idx + 2'd1);
                     uart_send_data <= 1'b1;
                     state          <= SEND;
                  end else if (row == LAST && col == LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FINISH;
                  end else begin
                     // Cross-word fetch waits one cycle longer than the initial fetch.
                     if (col == LAST) begin
                        col           <= '0;
                        row           <= row + CW'(1);
                        ram_c_rd_addr <= addr_of(row + CW'(1), '0);
                     end else begin
                        col           <= col + CW'(1);
                        ram_c_rd_addr <= addr_of(row, col + CW'(1));
                     end
                     rd_cnt <= 2'(RD_LAT);
                     state  <= RD_WAIT;
                  end
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_result_unload.sv
// tb/tb_fsm_result_unload.sv - self-checking bench: N=2/RD_LAT=1 directed runs and N=4/RD_LAT=2 random-delay run
module tb_fsm_result_unload;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A: N=2, RD_LAT=1
   logic        start_a, send_a, busy_a, done_a, tx_done_a, auto_a, spur_a;
   logic [10:0] addr_a;
   logic [31:0] rd_a;
   logic [7:0]  tx_data_a;
   logic [3:0]  state_a;
   logic [31:0] mem_a [4];
   int          dly_a, cnt_a;

   // instance B: N=4, RD_LAT=2
   logic        start_b, send_b, busy_b, done_b, tx_done_b;
   logic [10:0] addr_b;
   logic [31:0] rd_b, rd_b1;
   logic [7:0]  tx_data_b;
   logic [3:0]  state_b;
   logic [31:0] mem_b [16];
   int          cnt_b;

   fsm_result_unload #(.N(2), .ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .ram_c_rd_addr(addr_a), .ram_c_rd_data(rd_a),
      .uart_tx_data(tx_data_a), .uart_send_data(send_a), .uart_tx_done(tx_done_a),
      .busy(busy_a), .done(done_a), .state_val(state_a));

   fsm_result_unload #(.N(4), .ADDR_W(11), .DATA_W(32), .RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ram_c_rd_addr(addr_b), .ram_c_rd_data(rd_b),
      .uart_tx_data(tx_data_b), .uart_send_data(send_b), .uart_tx_done(tx_done_b),
      .busy(busy_b), .done(done_b), .state_val(state_b));

   always @(posedge clk) begin
      rd_a  <= mem_a[addr_a[1:0]];
      rd_b1 <= mem_b[addr_b[3:0]];
      rd_b  <= rd_b1;
   end

   // uart_tx models: answer each send with a tx_done pulse after a delay
   assign tx_done_a = auto_a | spur_a;
   always @(negedge clk) begin
      auto_a = 1'b0;
      if (rst) cnt_a = 0;
      else begin
         if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) auto_a = 1'b1; end
         if (send_a) cnt_a = dly_a;
      end
   end
   always @(negedge clk) begin
      tx_done_b = 1'b0;
      if (rst) cnt_b = 0;
      else begin
         if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) tx_done_b = 1'b1; end
         if (send_b) cnt_b = $urandom_range(20, 1);
      end
   end

   logic [7:0]  q_a[$], q_b[$];
   logic [10:0] ad_a[$], ad_b[$];
   int          sc_a[$], sc_b[$];
   int          sends_a, dones_a, sends_b, dones_b;
   always @(negedge clk) begin
      if (send_a) begin q_a.push_back(tx_data_a); sc_a.push_back(cyc); sends_a++; end
      if (state_a == 4'd2) ad_a.push_back(addr_a);
      if (done_a) dones_a++;
      if (send_b) begin q_b.push_back(tx_data_b); sc_b.push_back(cyc); sends_b++; end
      if (state_b == 4'd2) ad_b.push_back(addr_b);
      if (done_b) dones_b++;
   end

   typedef struct {
      logic [31:0] word;
      logic [7:0]  b [4];
      logic [10:0] addr;
   } vec_t;
   vec_t tbl [4];

   int n_chk = 0;
   int n_fail = 0;
   int ts;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic clear_a();
      q_a.delete(); ad_a.delete(); sc_a.delete(); sends_a = 0; dones_a = 0;
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1; ts = cyc;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int k = 0;
      while (!done_a && k < 2000) begin @(negedge clk); k++; end
      chk({tag, " done seen"}, done_a, 1'b1);
      #1;
   endtask

   task automatic check_stream_a(input string tag);
      chk({tag, " sends"}, sends_a, 16);
      chk({tag, " dones"}, dones_a, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s addr%0d", tag, i), (ad_a.size() > i) ? 64'(ad_a[i]) : 'x, 64'(tbl[i].addr));
         for (int k = 0; k < 4; k++)
            chk($sformatf("%s byte%0d", tag, 4*i+k), (q_a.size() > 4*i+k) ? 64'(q_a[4*i+k]) : 'x, 64'(tbl[i].b[k]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h3F800000, '{8'h3F, 8'h80, 8'h00, 8'h00}, 11'd0};
      tbl[1] = '{32'h40000000, '{8'h40, 8'h00, 8'h00, 8'h00}, 11'd1};
      tbl[2] = '{32'h40400000, '{8'h40, 8'h40, 8'h00, 8'h00}, 11'd2};
      tbl[3] = '{32'h40800000, '{8'h40, 8'h80, 8'h00, 8'h00}, 11'd3};
      for (int i = 0; i < 4; i++) mem_a[i] = tbl[i].word;
      for (int i = 0; i < 16; i++) mem_b[i] = $urandom;

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; spur_a = 1'b0; dly_a = 10;
      clear_a(); sends_b = 0; dones_b = 0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {addr_a, tx_data_a, send_a, busy_a, done_a, state_a}, '0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle after reset", {state_a, busy_a}, '0);

      // run 1: tx_done 10 cycles after each send; start during done is ignored
      clear_a(); pulse_start_a();
      chk("busy after start", busy_a, 1'b1);
      wait_done_a("r1");
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (5) @(negedge clk);
      check_stream_a("r1");
      chk("r1 start-at-done ignored", {state_a, busy_a, 32'(sends_a)}, {4'd0, 1'b0, 32'd16});

      // run 2: immediate tx_done, latency checks, then back-to-back run
      dly_a = 1; clear_a(); pulse_start_a();
      wait_done_a("r2");
      chk("r2 first send latency", sc_a[0] - ts, 3);
      chk("r2 in-word send gap", sc_a[1] - sc_a[0], 2);
      chk("r2 cross-word send gap", sc_a[4] - sc_a[3], 5);
      check_stream_a("r2");
      @(negedge clk);
      clear_a(); pulse_start_a();
      wait_done_a("r3");
      chk("r3 first send latency", sc_a[0] - ts, 3);
      check_stream_a("r3");

      // run 4: spurious tx_done in idle, second start while busy
      dly_a = 4; clear_a();
      spur_a = 1'b1;
      repeat (3) @(negedge clk);
      spur_a = 1'b0;
      @(negedge clk);
      chk("spurious idle", {state_a, 32'(sends_a)}, '0);
      pulse_start_a();
      repeat (4) @(negedge clk);
      pulse_start_a();
      wait_done_a("r4");
      repeat (6) @(negedge clk);
      check_stream_a("r4");

      // run 5: reset after the 6th tx_done, then a fresh run from address 0
      begin
         int n = 0;
         int k = 0;
         dly_a = 3; clear_a(); pulse_start_a();
         while (n < 6 && k < 1000) begin @(posedge clk); if (tx_done_a) n++; k++; end
         chk("r5 six tx_done", n, 6);
         #2 rst = 1'b1;
         #1;
         chk("r5 reset mid-run outputs", {addr_a, tx_data_a, send_a, busy_a, done_a, state_a}, '0);
         chk("r5 sends before reset", sends_a, 6);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         repeat (10) @(negedge clk);
         chk("r5 no sends after reset", {state_a, 32'(sends_a)}, {4'd0, 32'd6});
         dly_a = 2; clear_a(); pulse_start_a();
         wait_done_a("r5b");
         repeat (2) @(negedge clk);
         check_stream_a("r5b");
      end

      // run B: N=4, RD_LAT=2, random tx_done delays, checked against row-major MSB-first model
      begin
         int k = 0;
         start_b = 1'b1; ts = cyc;
         @(negedge clk);
         start_b = 1'b0;
         while (!done_b && k < 5000) begin @(negedge clk); k++; end
         chk("rb done seen", done_b, 1'b1);
         repeat (3) @(negedge clk);
         chk("rb sends", sends_b, 64);
         chk("rb dones", dones_b, 1);
         chk("rb first send latency", sc_b[0] - ts, 4);
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("rb addr%0d", i), (ad_b.size() > i) ? 64'(ad_b[i]) : 'x, 64'(i));
            for (int j = 0; j < 4; j++)
               chk($sformatf("rb byte%0d", 4*i+j), (q_b.size() > 4*i+j) ? 64'(q_b[4*i+j]) : 'x,
                   64'((mem_b[i] >> (24 - 8*j)) & 32'hFF));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
